// File: rtl/seg7_scan_if.sv
// Host-side bundle for the four-digit display driver: the display request
// (value, per-digit controls, load strobe) and the multiplexed pin outputs.
interface seg7_scan_if;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dp;
   logic [3:0]  blank;
   logic [3:0]  blink;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp_n;
   logic        frame;

   modport master (
      output load, value, dp, blank, blink,
      input  an, seg, dp_n, frame
   );

   modport slave (
      input  load, value, dp, blank, blink,
      output an, seg, dp_n, frame
   );
endinterface

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver: per-slot blanking gap, blink
// control, and a pending/active register pair swapped only at slot boundaries.
module seg7_scan #(
   parameter int DIGIT_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500,
   parameter int BLINK_FRAMES = 128
) (
   input  logic       clk,
   input  logic       rst_n,
   seg7_scan_if.slave bus
);
   localparam int CYC_W = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
   localparam int FRM_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(DIGIT_CYCLES - 1);
   localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

   typedef struct packed {
      logic [15:0] value;
      logic [3:0]  dp;
      logic [3:0]  blank;
      logic [3:0]  blink;
   } disp_t;

   localparam disp_t DISP_RST = '{value: 16'h0000, dp: 4'h0, blank: 4'hF, blink: 4'h0};

   function automatic logic [6:0] f_hex7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   disp_t            r_pend;
   disp_t            r_act;
   logic [CYC_W-1:0] r_cyc;
   logic [1:0]       r_idx;
   logic [FRM_W-1:0] r_frm;
   logic             r_blink_phase;
   logic [3:0]       r_an;
   logic [6:0]       r_seg;
   logic             r_dp_n;
   logic             r_frame;

   logic             w_cyc_wrap;
   logic             w_idx_wrap;
   logic             w_frm_wrap;
   logic             w_in_blank;
   logic             w_dark;
   logic             w_drive;
   logic [6:0]       w_seg_dig [4];

   assign w_cyc_wrap = (r_cyc == CYC_LAST);
   assign w_idx_wrap = w_cyc_wrap && (r_idx == 2'd3);
   assign w_frm_wrap = w_idx_wrap && (r_frm == FRM_LAST);

   // With no gap configured the comparison would be constant-false, so drop it.
   generate
      if (BLANK_CYCLES == 0) begin : g_no_gap
         assign w_in_blank = 1'b0;
      end else begin : g_gap
         assign w_in_blank = (r_cyc < CYC_W'(BLANK_CYCLES));
      end
   endgenerate

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_dig
         assign w_seg_dig[gi] = f_hex7(r_act.value[4*gi +: 4]);
      end
   endgenerate

   assign w_dark  = r_act.blank[r_idx] | (r_act.blink[r_idx] & r_blink_phase);
   assign w_drive = ~w_in_blank & ~w_dark;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cyc         <= '0;
         r_idx         <= 2'd0;
         r_frm         <= '0;
         r_blink_phase <= 1'b0;
      end else begin
         r_cyc <= w_cyc_wrap ? '0 : r_cyc + 1'b1;
         if (w_cyc_wrap) begin
            r_idx <= r_idx + 2'd1;
         end
         if (w_idx_wrap) begin
            r_frm <= (r_frm == FRM_LAST) ? '0 : r_frm + 1'b1;
         end
         if (w_frm_wrap) begin
            r_blink_phase <= ~r_blink_phase;
         end
      end
   end

   // The active set only changes at a slot boundary; a load on that same edge
   // lands in pending and waits for the next boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= DISP_RST;
         r_act  <= DISP_RST;
      end else begin
         if (bus.load) begin
            r_pend <= '{value: bus.value, dp: bus.dp, blank: bus.blank, blink: bus.blink};
         end
         if (w_cyc_wrap) begin
            r_act <= r_pend;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_an    <= 4'hF;
         r_seg   <= 7'h7F;
         r_dp_n  <= 1'b1;
         r_frame <= 1'b0;
      end else begin
         r_an    <= w_drive ? ~(4'b0001 << r_idx) : 4'hF;
         r_seg   <= w_drive ? w_seg_dig[r_idx] : 7'h7F;
         r_dp_n  <= ~(w_drive & r_act.dp[r_idx]);
         r_frame <= (r_cyc == '0) && (r_idx == 2'd0);
      end
   end

   assign bus.an    = r_an;
   assign bus.seg   = r_seg;
   assign bus.dp_n  = r_dp_n;
   assign bus.frame = r_frame;
endmodule
